adc_channel_scheduler: RTL and testbench

ADC_CHANNEL_SCHEDULER -- requirements
Module: adc_channel_scheduler

---
 rtl/adc_sched_pkg.sv | 24 ++
 rtl/adc_channel_scheduler_if.sv | 31 +++
 rtl/sample_fifo2.sv | 62 ++++++
 rtl/adc_channel_scheduler.sv | 140 ++++++++++++++
 tb/tb_adc_channel_scheduler.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC channel scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package adc_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_NEXT  = 2'd3
    } sched_state_e;

    // Wide enough for 125 MHz / 1 Hz frames and very long conversion budgets.
    localparam int TICK_CNT_W = 32;
    localparam int TMO_CNT_W  = 32;

    localparam int SMP_W = 12;

    typedef struct packed {
        logic             ch;
        logic [SMP_W-1:0] dat;
    } smp_entry_t;

endpackage

// File: rtl/adc_channel_scheduler_if.sv
// Bundle between scheduler, SPI ADC engine and the sample consumer.
// Latency: n/a (wires only).
// Backpressure: smp_valid/smp_ready handshake on the result stream.
// master = scheduler side, slave = engine + consumer side.
interface adc_channel_scheduler_if;

    logic                            conv_start;
    logic                            conv_sgl;
    logic                            conv_odd;
    logic                            conv_done;
    logic [adc_sched_pkg::SMP_W-1:0] conv_data;
    logic                            smp_valid;
    logic                            smp_ready;
    logic [adc_sched_pkg::SMP_W-1:0] smp_data;
    logic                            smp_ch;

    modport master (
        output conv_start, conv_sgl, conv_odd,
        input  conv_done, conv_data,
        output smp_valid, smp_data, smp_ch,
        input  smp_ready
    );

    modport slave (
        input  conv_start, conv_sgl, conv_odd,
        output conv_done, conv_data,
        input  smp_valid, smp_data, smp_ch,
        output smp_ready
    );

endinterface

// File: rtl/sample_fifo2.sv
// Two-entry result FIFO {channel, 12-bit sample}.
// Latency: push visible at pop side one clk later.
// Backpressure: push into a full FIFO without a same-cycle pop is dropped and flagged on drop.
// Ports: push_vld/push_dat in, drop out, pop_vld/pop_dat out, pop_rdy in.
module sample_fifo2
    import adc_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_vld,
    input  smp_entry_t push_dat,
    output logic       drop,
    output logic       pop_vld,
    input  logic       pop_rdy,
    output smp_entry_t pop_dat
);

    smp_entry_t e0_q, e0_d;
    smp_entry_t e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pop;
    logic       push_ok;

    always_comb begin
        pop     = (cnt_q != 2'd0) && pop_rdy;
        push_ok = push_vld && ((cnt_q != 2'd2) || pop);
        drop    = push_vld && !push_ok;
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        // e0 is always the head; a pop shifts e1 down first, then the push
        // lands in the first free slot of the post-pop occupancy.
        if (pop) begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
        end
        if (push_ok) begin
            if (cnt_d == 2'd0) begin
                e0_d = push_dat;
            end else begin
                e1_d = push_dat;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign pop_vld = (cnt_q != 2'd0);
    assign pop_dat = e0_q;

endmodule

// File: rtl/adc_channel_scheduler.sv
// Frame scheduler: every FCLK/SAMPLE_RATE clks converts each enabled ADC channel in turn.
// Latency: conv_done -> smp_valid one clk when the result FIFO is empty.
// Backpressure: 2-deep result FIFO; overflow drops the new result and sets sticky overrun.
// Ports: clk/rst_n, enable level, clr_err, sticky overrun/timeout_err, bus (engine + result stream).
module adc_channel_scheduler
    import adc_sched_pkg::*;
#(
    parameter real        FCLK        = 125e6,
    parameter int         SAMPLE_RATE = 500,
    parameter logic [1:0] CH_MASK     = 2'b11,
    parameter bit         DIFF        = 1'b0,
    parameter int         TIMEOUT     = 40000
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    clr_err,
    output logic                    overrun,
    output logic                    timeout_err,
    adc_channel_scheduler_if.master bus
);

    localparam int TICK_DIV = int'(FCLK / SAMPLE_RATE);
    localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(TICK_DIV - 1);
    localparam logic [TMO_CNT_W-1:0]  TMO_LAST  = TMO_CNT_W'(TIMEOUT - 1);

    sched_state_e          state_q, state_d;
    logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TMO_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic                  ch_q, ch_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_err_q, timeout_err_d;

    logic       tick;
    logic       push_vld;
    logic       tmo_evt;
    logic       fifo_drop;
    smp_entry_t push_dat;
    smp_entry_t pop_dat;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        state_d    = state_q;
        ch_d       = ch_q;
        wait_cnt_d = wait_cnt_q;
        push_vld   = 1'b0;
        tmo_evt    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick && enable && (CH_MASK != 2'b00)) begin
                    // Lowest enabled channel: CH0 unless it is masked off.
                    ch_d    = ~CH_MASK[0];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.conv_done) begin
                    push_vld = 1'b1;
                    state_d  = ST_NEXT;
                end else if (wait_cnt_q == TMO_LAST) begin
                    tmo_evt = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_NEXT: begin
                // Only two channels, so CH1 is the only possible successor.
                if (!ch_q && CH_MASK[1]) begin
                    ch_d    = 1'b1;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky flags: clear first so a same-cycle set event wins.
    always_comb begin
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        if (clr_err) begin
            overrun_d     = 1'b0;
            timeout_err_d = 1'b0;
        end
        if ((tick && (state_q != ST_IDLE)) || fifo_drop) begin
            overrun_d = 1'b1;
        end
        if (tmo_evt) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            tick_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            ch_q          <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            ch_q          <= ch_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign push_dat = {ch_q, bus.conv_data};

    sample_fifo2 u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .drop     (fifo_drop),
        .pop_vld  (bus.smp_valid),
        .pop_rdy  (bus.smp_ready),
        .pop_dat  (pop_dat)
    );

    assign bus.conv_start = (state_q == ST_START);
    assign bus.conv_sgl   = ~DIFF;
    assign bus.conv_odd   = ch_q;
    assign bus.smp_ch     = pop_dat.ch;
    assign bus.smp_data   = pop_dat.dat;
    assign overrun        = overrun_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Directed bench: four scheduler instances (mask 11, mask 11 + short timeout, mask 10, mask 00 diff).
// Latency: engine models answer a fixed number of clks after conv_start.
// Backpressure: smp_ready driven per scenario on instance A.
module tb_adc_channel_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en_a, en_b, en_c, en_d;
    logic clr_a, clr_b, clr_c, clr_d;
    logic ovr_a, ovr_b, ovr_c, ovr_d;
    logic tmo_a, tmo_b, tmo_c, tmo_d;

    adc_channel_scheduler_if ia();
    adc_channel_scheduler_if ib();
    adc_channel_scheduler_if ic();
    adc_channel_scheduler_if id();

    adc_channel_scheduler #(.FCLK(1e6), .SAMPLE_RATE(1000), .CH_MASK(2'b11), .DIFF(1'b0), .TIMEOUT(40000)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .clr_err(clr_a),
        .overrun(ovr_a), .timeout_err(tmo_a), .bus(ia));
    adc_channel_scheduler #(.FCLK(1e6), .SAMPLE_RATE(1000), .CH_MASK(2'b11), .DIFF(1'b0), .TIMEOUT(50)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .clr_err(clr_b),
        .overrun(ovr_b), .timeout_err(tmo_b), .bus(ib));
    adc_channel_scheduler #(.FCLK(1e6), .SAMPLE_RATE(1000), .CH_MASK(2'b10), .DIFF(1'b0), .TIMEOUT(40000)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(en_c), .clr_err(clr_c),
        .overrun(ovr_c), .timeout_err(tmo_c), .bus(ic));
    adc_channel_scheduler #(.FCLK(1e6), .SAMPLE_RATE(1000), .CH_MASK(2'b00), .DIFF(1'b1), .TIMEOUT(40000)) dut_d (
        .clk(clk), .rst_n(rst_n), .enable(en_d), .clr_err(clr_d),
        .overrun(ovr_d), .timeout_err(tmo_d), .bus(id));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rel      = 0;
    int lat_a    = 100;
    bit stray_a  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Engine models: answer lat clks after seeing conv_start, 0x123 for CH0 and 0xABC for CH1.
    initial begin : eng_a
        int cnt;
        cnt = -1;
        ia.conv_done = 1'b0;
        ia.conv_data = '0;
        forever begin
            @(posedge clk); #1;
            ia.conv_done = 1'b0;
            if (!rst_n) cnt = -1;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ia.conv_done = 1'b1;
                    ia.conv_data = ia.conv_odd ? 12'hABC : 12'h123;
                    cnt = -1;
                end
            end
            if (stray_a) begin
                ia.conv_done = 1'b1;
                ia.conv_data = 12'h555;
                stray_a = 1'b0;
            end
            if (rst_n && ia.conv_start) cnt = lat_a;
        end
    end

    initial begin : eng_c
        int cnt;
        cnt = -1;
        ic.conv_done = 1'b0;
        ic.conv_data = '0;
        forever begin
            @(posedge clk); #1;
            ic.conv_done = 1'b0;
            if (!rst_n) cnt = -1;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ic.conv_done = 1'b1;
                    ic.conv_data = ic.conv_odd ? 12'hABC : 12'h123;
                    cnt = -1;
                end
            end
            if (rst_n && ic.conv_start) cnt = 100;
        end
    end

    // Monitors sample on the falling edge; all drivers change just after the rising edge.
    int a_st_cyc[$], a_st_odd[$], a_smp[$];
    int b_st_cyc[$], b_st_odd[$];
    int c_st_odd[$], c_smp[$];
    int d_nst, a_run, a_maxrun, a_lat, a_done_cyc, b_tmo_cyc;
    bit a_pv;

    always @(negedge clk) begin
        if (ia.conv_start) begin
            a_st_cyc.push_back(cyc);
            a_st_odd.push_back(int'(ia.conv_odd));
            a_run++;
            if (a_run > a_maxrun) a_maxrun = a_run;
        end else begin
            a_run = 0;
        end
        if (ia.smp_valid && ia.smp_ready) a_smp.push_back(int'({ia.smp_ch, ia.smp_data}));
        if (ia.conv_done) a_done_cyc = cyc;
        if (ia.smp_valid && !a_pv && (a_lat < 0)) a_lat = cyc - a_done_cyc;
        a_pv = ia.smp_valid;
        if (ib.conv_start) begin
            b_st_cyc.push_back(cyc);
            b_st_odd.push_back(int'(ib.conv_odd));
        end
        if (tmo_b && (b_tmo_cyc < 0)) b_tmo_cyc = cyc;
        if (ic.conv_start) c_st_odd.push_back(int'(ic.conv_odd));
        if (ic.smp_valid && ic.smp_ready) c_smp.push_back(int'({ic.smp_ch, ic.smp_data}));
        if (id.conv_start) d_nst++;
    end

    task automatic clear_logs();
        a_st_cyc.delete(); a_st_odd.delete(); a_smp.delete();
        b_st_cyc.delete(); b_st_odd.delete();
        c_st_odd.delete(); c_smp.delete();
        d_nst = 0; a_run = 0; a_maxrun = 0; a_lat = -1; a_done_cyc = 0; b_tmo_cyc = -1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic step_to(input int t);
        while (cyc - rel < t) step(1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step(3);
        clear_logs();
        rst_n = 1'b1;
        rel = cyc;
    endtask

    initial begin
        rst_n = 1'b1;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0; clr_d = 1'b0;
        ia.smp_ready = 1'b1; ib.smp_ready = 1'b1; ic.smp_ready = 1'b1; id.smp_ready = 1'b1;
        clear_logs();
        #1 rst_n = 1'b0;
        step(3);

        // Reset state.
        check_val("rst_start", 32'(ia.conv_start), 0);
        check_val("rst_odd", 32'(ia.conv_odd), 0);
        check_val("rst_valid", 32'(ia.smp_valid), 0);
        check_val("rst_data", {19'd0, ia.smp_ch, ia.smp_data}, 0);
        check_val("rst_flags", {30'd0, ovr_a, tmo_a}, 0);
        check_val("sgl_single", 32'(ia.conv_sgl), 1);
        check_val("sgl_diff", 32'(id.conv_sgl), 0);

        // Round-robin on A, CH1-only on C, nothing on D; enable dropped mid-frame 2.
        en_a = 1'b1; en_c = 1'b1; en_d = 1'b1; lat_a = 100;
        clear_logs();
        rst_n = 1'b1;
        rel = cyc;
        step_to(2050);
        en_a = 1'b0; en_c = 1'b0;
        step_to(3300);
        check_val("rr_first_tick", q_at(a_st_cyc, 0) - rel, 1000);
        check_val("rr_period", q_at(a_st_cyc, 2) - q_at(a_st_cyc, 0), 1000);
        check_val("rr_nstart", a_st_odd.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("rr_odd%0d", i), q_at(a_st_odd, i), i % 2);
            check_val($sformatf("rr_smp%0d", i), q_at(a_smp, i), (i % 2 == 1) ? 32'h1ABC : 32'h0123);
        end
        check_val("rr_start_len", a_maxrun, 1);
        check_val("rr_latency", a_lat, 1);
        check_val("rr_flags", {30'd0, ovr_a, tmo_a}, 0);
        check_val("mask10_nstart", c_st_odd.size(), 2);
        check_val("mask10_odd0", q_at(c_st_odd, 0), 1);
        check_val("mask10_odd1", q_at(c_st_odd, 1), 1);
        check_val("mask10_smp0", q_at(c_smp, 0), 32'h1ABC);
        check_val("mask10_smp1", q_at(c_smp, 1), 32'h1ABC);
        check_val("mask00_nstart", d_nst, 0);
        check_val("mask00_flags", {28'd0, ovr_c, tmo_c, ovr_d, tmo_d}, 0);
        stray_a = 1'b1;
        step(5);
        check_val("stray_nsmp", a_smp.size(), 4);
        check_val("stray_valid", 32'(ia.smp_valid), 0);
        en_d = 1'b0;

        // Backpressure: three frames with smp_ready low.
        en_a = 1'b1; ia.smp_ready = 1'b0;
        apply_reset();
        step_to(1300);
        check_val("bp_full_ovr", 32'(ovr_a), 0);
        check_val("bp_full_valid", 32'(ia.smp_valid), 1);
        check_val("bp_head", {19'd0, ia.smp_ch, ia.smp_data}, 32'h0123);
        step_to(3300);
        check_val("bp_ovr", 32'(ovr_a), 1);
        en_a = 1'b0; ia.smp_ready = 1'b1;
        step(5);
        check_val("bp_nsmp", a_smp.size(), 2);
        check_val("bp_smp0", q_at(a_smp, 0), 32'h0123);
        check_val("bp_smp1", q_at(a_smp, 1), 32'h1ABC);
        check_val("bp_drained", 32'(ia.smp_valid), 0);
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        check_val("bp_clr", 32'(ovr_a), 0);

        // Frame overrun: conversion longer than the frame period.
        en_a = 1'b1; lat_a = 1200;
        apply_reset();
        step_to(1990);
        check_val("fo_before", 32'(ovr_a), 0);
        step_to(2010);
        check_val("fo_after", 32'(ovr_a), 1);
        en_a = 1'b0;
        step_to(3600);
        check_val("fo_nstart", a_st_odd.size(), 2);
        check_val("fo_odd1", q_at(a_st_odd, 1), 1);
        check_val("fo_nsmp", a_smp.size(), 2);
        check_val("fo_tmo", 32'(tmo_a), 0);

        // Reset during CH1 WAIT of frame 2 with a full FIFO.
        en_a = 1'b1; lat_a = 100; ia.smp_ready = 1'b0;
        apply_reset();
        step_to(2150);
        check_val("mr_pre_odd", 32'(ia.conv_odd), 1);
        check_val("mr_pre_ovr", 32'(ovr_a), 1);
        rst_n = 1'b0;
        step(3);
        check_val("mr_outs", {18'd0, ia.conv_start, ia.conv_odd, ia.smp_valid, ia.smp_ch, ia.smp_data}, 0);
        check_val("mr_flags", {30'd0, ovr_a, tmo_a}, 0);
        clear_logs();
        ia.smp_ready = 1'b1;
        rst_n = 1'b1;
        rel = cyc;
        step_to(1500);
        en_a = 1'b0;
        check_val("mr_first_tick", q_at(a_st_cyc, 0) - rel, 1000);
        check_val("mr_nsmp", a_smp.size(), 2);
        check_val("mr_smp0", q_at(a_smp, 0), 32'h0123);
        check_val("mr_smp1", q_at(a_smp, 1), 32'h1ABC);

        // Timeout on B: engine never answers.
        en_b = 1'b1;
        apply_reset();
        step_to(1300);
        check_val("to_nstart", b_st_odd.size(), 2);
        check_val("to_start0", q_at(b_st_cyc, 0) - rel, 1000);
        check_val("to_next_gap", q_at(b_st_cyc, 1) - q_at(b_st_cyc, 0), 52);
        check_val("to_err_cyc", b_tmo_cyc - q_at(b_st_cyc, 0), 51);
        check_val("to_odd0", q_at(b_st_odd, 0), 0);
        check_val("to_odd1", q_at(b_st_odd, 1), 1);
        check_val("to_flag", 32'(tmo_b), 1);
        check_val("to_no_smp", 32'(ib.smp_valid), 0);
        check_val("to_no_ovr", 32'(ovr_b), 0);
        clr_b = 1'b1;
        step(1);
        clr_b = 1'b0;
        check_val("to_clr", 32'(tmo_b), 0);

        // Set wins over a clear held in the same cycle.
        clr_b = 1'b1;
        apply_reset();
        step_to(1051);
        check_val("setwin_set", 32'(tmo_b), 1);
        step(1);
        check_val("setwin_clr", 32'(tmo_b), 0);
        clr_b = 1'b0; en_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
